// File: rtl/wb_ipi_mailbox.sv
// wb_ipi_mailbox: inter-processor interrupt mailbox behind a Wishbone B3 slave.
// One FIFO per receiving core. Each FIFO has a sticky overflow flag and an
// interrupt enable. Every Wishbone access gets a single registered response.
//
// Address map: adr[5:4] selects mailbox m, adr[3:2] selects the register.
//   0 DATA   : write pushes into FIFO m; read pops the FIFO head (reads 0 when empty)
//   1 STATUS : [0] empty, [1] full, [2] overflow (write 1 to clear), [7:3] count
//   2 CTRL   : [0] irq enable (written when sel[0]=1)
//   3 reserved, reads 0
//
// Ports:
//   wb_clk_i, wb_rst_ni          clock, asynchronous active-low reset
//   wb_adr_i .. wb_bte_i         Wishbone B3 slave inputs (cti/bte ignored)
//   wb_dat_o, wb_ack_o, wb_err_o registered response; wb_rty_o is tied to 0
//   irq_o[NUM_CORES]             registered (enable & ~empty) for each mailbox
//
// Optional feature: WB_IPI_MAILBOX_OVERFLOW_ERR_EN. When this macro is defined,
// a DATA write to a full FIFO answers with wb_err_o instead of wb_ack_o.
module wb_ipi_mailbox #(
  parameter int NUM_CORES  = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  input  logic [31:0]          wb_adr_i,
  input  logic [31:0]          wb_dat_i,
  input  logic [3:0]           wb_sel_i,
  input  logic                 wb_we_i,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  input  logic [2:0]           wb_cti_i,
  input  logic [1:0]           wb_bte_i,
  output logic [31:0]          wb_dat_o,
  output logic                 wb_ack_o,
  output logic                 wb_err_o,
  output logic                 wb_rty_o,
  output logic [NUM_CORES-1:0] irq_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

`ifdef WB_IPI_MAILBOX_OVERFLOW_ERR_EN
  localparam logic OVF_ERR = 1'b1;
`else
  localparam logic OVF_ERR = 1'b0;
`endif

  logic [31:0]          mem    [NUM_CORES][FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr [NUM_CORES];
  logic [PW-1:0]        rd_ptr [NUM_CORES];
  logic [CW-1:0]        count  [NUM_CORES];
  logic [NUM_CORES-1:0] ovf;
  logic [NUM_CORES-1:0] irq_en;

  logic                 access;
  logic [1:0]           mbx;
  logic [1:0]           reg_sel;
  logic [NUM_CORES-1:0] hit;
  logic [NUM_CORES-1:0] empty_v;
  logic [NUM_CORES-1:0] full_v;
  logic [31:0]          rd_data;
  logic                 ovf_err;
  logic                 unused_bits;

  // The ~ack/~err terms keep a held strobe from starting a second access in
  // the response cycle. The next access can only begin one cycle later.
  assign access  = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
  assign mbx     = wb_adr_i[5:4];
  assign reg_sel = wb_adr_i[3:2];
  assign wb_rty_o = 1'b0;

  assign unused_bits = ^{wb_adr_i[31:6], wb_adr_i[1:0], wb_sel_i[3:1], wb_cti_i, wb_bte_i};

  // A mailbox index at or above NUM_CORES hits no mailbox. Such an access
  // still gets an ack, reads 0 and changes nothing.
  always_comb begin
    hit     = '0;
    empty_v = '0;
    full_v  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      hit[i]     = (mbx == 2'(i));
      empty_v[i] = (count[i] == '0);
      full_v[i]  = (count[i] == CW'(FIFO_DEPTH));
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (hit[i]) begin
        case (reg_sel)
          REG_DATA:   if (!empty_v[i]) rd_data = mem[i][rd_ptr[i]];
          REG_STATUS: rd_data = {24'd0, 5'(count[i]), ovf[i], full_v[i], empty_v[i]};
          REG_CTRL:   rd_data = {31'd0, irq_en[i]};
          default:    rd_data = '0;
        endcase
      end
    end
  end

  assign ovf_err = OVF_ERR & access & wb_we_i & (reg_sel == REG_DATA) & (|(hit & full_v));

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
      irq_o    <= '0;
      ovf      <= '0;
      irq_en   <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
        for (int j = 0; j < FIFO_DEPTH; j++) mem[i][j] <= '0;
      end
    end else begin
      wb_ack_o <= access & ~ovf_err;
      wb_err_o <= ovf_err;
      wb_dat_o <= (access & ~wb_we_i) ? rd_data : 32'd0;
      // irq_o is sampled from the state before this edge. It therefore
      // follows a push or pop one cycle after the response.
      irq_o    <= irq_en & ~empty_v;
      if (access) begin
        for (int i = 0; i < NUM_CORES; i++) begin
          if (hit[i]) begin
            case (reg_sel)
              REG_DATA: begin
                if (wb_we_i) begin
                  if (full_v[i]) begin
                    ovf[i] <= 1'b1;
                  end else begin
                    mem[i][wr_ptr[i]] <= wb_dat_i;
                    wr_ptr[i]         <= wr_ptr[i] + 1'b1;
                    count[i]          <= count[i] + 1'b1;
                  end
                end else if (!empty_v[i]) begin
                  rd_ptr[i] <= rd_ptr[i] + 1'b1;
                  count[i]  <= count[i] - 1'b1;
                end
              end
              REG_STATUS: if (wb_we_i && wb_dat_i[2]) ovf[i] <= 1'b0;
              REG_CTRL:   if (wb_we_i && wb_sel_i[0]) irq_en[i] <= wb_dat_i[0];
              default: ;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_ipi_mailbox.sv
module tb_wb_ipi_mailbox;

  localparam int NC = 2;
`ifdef WB_IPI_MAILBOX_OVERFLOW_ERR_EN
  localparam logic OVF_ERR = 1'b1;
`else
  localparam logic OVF_ERR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   adr = '0, dat_i = '0, dat_o;
  logic [3:0]    sel = '0;
  logic          we = 1'b0, cyc = 1'b0, stb = 1'b0;
  logic [2:0]    cti = '0;
  logic [1:0]    bte = '0;
  logic          ack, err, rty;
  logic [NC-1:0] irq;

  wb_ipi_mailbox #(.NUM_CORES(NC), .FIFO_DEPTH(4)) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .wb_adr_i (adr),
    .wb_dat_i (dat_i),
    .wb_sel_i (sel),
    .wb_we_i  (we),
    .wb_cyc_i (cyc),
    .wb_stb_i (stb),
    .wb_cti_i (cti),
    .wb_bte_i (bte),
    .wb_dat_o (dat_o),
    .wb_ack_o (ack),
    .wb_err_o (err),
    .wb_rty_o (rty),
    .irq_o    (irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        err;
    logic [31:0] rdat;
    logic [1:0]  irq;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, act, exp);
    end
  endfunction

  function automatic void add(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic e, input logic [31:0] r,
                              input logic [1:0] q);
    vec_t v;
    v.we = w; v.adr = a; v.dat = d; v.sel = s; v.err = e; v.rdat = r; v.irq = q;
    vecs.push_back(v);
  endfunction

  function automatic void wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] q);
    add(1'b1, a, d, 4'hF, 1'b0, 32'd0, q);
  endfunction

  function automatic void rd(input logic [31:0] a, input logic [31:0] r, input logic [1:0] q);
    add(1'b0, a, 32'd0, 4'hF, 1'b0, r, q);
  endfunction

  // Run one classic access. The expected response is queued when the access
  // is driven and popped when the DUT answers. After that, check that the
  // response lasted one cycle and check the irq vector.
  task automatic run(input vec_t v, input int idx);
    vec_t e;
    int   n;
    logic got;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = v.we; adr = v.adr; dat_i = v.dat; sel = v.sel;
    cti = 3'(idx); bte = 2'(idx);
    sb.push_back(v);
    n = 0; got = 1'b0;
    while (!got && n < 6) begin
      @(negedge clk);
      n++;
      got = ack | err;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    e = sb.pop_front();
    if (!got) begin
      chk($sformatf("v%0d_timeout", idx), 32'd0, 32'd1);
    end else begin
      chk($sformatf("v%0d_latency", idx), 32'(n), 32'd1);
      chk($sformatf("v%0d_ack", idx), {31'd0, ack}, {31'd0, ~e.err});
      chk($sformatf("v%0d_err", idx), {31'd0, err}, {31'd0, e.err});
      chk($sformatf("v%0d_dat", idx), dat_o, e.rdat);
    end
    @(negedge clk);
    chk($sformatf("v%0d_one_cycle", idx), {30'd0, ack, err}, 32'd0);
    chk($sformatf("v%0d_dat_idle", idx), dat_o, 32'd0);
    chk($sformatf("v%0d_irq", idx), {30'd0, irq}, {30'd0, v.irq});
  endtask

  localparam logic [31:0] D0 = 32'h00, S0 = 32'h04, C0 = 32'h08, R0 = 32'h0C;
  localparam logic [31:0] D1 = 32'h10, S1 = 32'h14, C1 = 32'h18;
  localparam logic [31:0] D3 = 32'h30;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   seen;
    vec_t v;

    // Basic irq path: enable mailbox 1, push, then read status
    wr(C1, 32'h1, 2'b00);
    wr(D1, 32'hDEADBEEF, 2'b10);
    rd(S1, 32'h08, 2'b10);
    // Fill mailbox 0, overflow it, clear the overflow flag, then drain
    for (int k = 1; k <= 4; k++) wr(D0, 32'(k), 2'b10);
    rd(S0, 32'h22, 2'b10);
    add(1'b1, D0, 32'h5, 4'hF, OVF_ERR, 32'd0, 2'b10);
    rd(S0, 32'h26, 2'b10);
    wr(S0, 32'h4, 2'b10);
    rd(S0, 32'h22, 2'b10);
    for (int k = 1; k <= 4; k++) rd(D0, 32'(k), 2'b10);
    rd(D0, 32'h0, 2'b10);
    rd(S0, 32'h01, 2'b10);
    // Pointer wrap
    for (int k = 0; k < 3; k++) wr(D0, 32'h11 + 32'(k), 2'b10);
    for (int k = 0; k < 3; k++) rd(D0, 32'h11 + 32'(k), 2'b10);
    for (int k = 0; k < 4; k++) wr(D0, 32'hA + 32'(k), 2'b10);
    rd(S0, 32'h22, 2'b10);
    for (int k = 0; k < 4; k++) rd(D0, 32'hA + 32'(k), 2'b10);
    rd(S0, 32'h01, 2'b10);
    // CTRL byte-select gating; DATA push ignores sel
    add(1'b1, C0, 32'h1, 4'h0, 1'b0, 32'd0, 2'b10);
    rd(C0, 32'h0, 2'b10);
    add(1'b1, C0, 32'hFFFFFFFF, 4'h1, 1'b0, 32'd0, 2'b10);
    rd(C0, 32'h1, 2'b10);
    add(1'b1, D0, 32'h55, 4'h0, 1'b0, 32'd0, 2'b11);
    // Reserved register, mailbox index beyond NUM_CORES, upper address bits ignored
    rd(R0, 32'h0, 2'b11);
    wr(R0, 32'h1234, 2'b11);
    rd(D3, 32'h0, 2'b11);
    wr(D3, 32'h99, 2'b11);
    rd(32'h100 | S1, 32'h08, 2'b11);
    rd(D1, 32'hDEADBEEF, 2'b01);
    rd(S1, 32'h01, 2'b01);
    wr(D1, 32'h77, 2'b11);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_rty", {31'd0, rty}, 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    chk("rst_irq", {30'd0, irq}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run(vecs[i], i);

    // A strobe withdrawn before the clock edge gets no response and pops nothing
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = D0;
    #2;
    cyc = 1'b0; stb = 1'b0;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (ack || err) seen++;
    end
    chk("withdraw_no_resp", 32'(seen), 32'd0);
    v = '{we: 1'b0, adr: S0, dat: 32'd0, sel: 4'hF, err: 1'b0, rdat: 32'h08, irq: 2'b11};
    run(v, 100);

    // A strobe held high gets one response, not back-to-back responses
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = S0;
    @(negedge clk);
    chk("hold_ack", {31'd0, ack}, 32'd1);
    chk("hold_dat", dat_o, 32'h08);
    @(negedge clk);
    chk("hold_no_b2b", {31'd0, ack}, 32'd0);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);

    // Reset during a pending read while both irqs are asserted
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = D0;
    @(posedge clk);
    #2;
    chk("pre_rst_irq", {30'd0, irq}, 32'd3);
    chk("pre_rst_dat", dat_o, 32'h55);
    rst_n = 1'b0;
    #1;
    chk("async_rst_irq", {30'd0, irq}, 32'd0);
    chk("async_rst_ack", {31'd0, ack}, 32'd0);
    chk("async_rst_dat", dat_o, 32'd0);
    repeat (2) @(negedge clk);
    chk("in_rst_ack", {31'd0, ack}, 32'd0);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    v = '{we: 1'b0, adr: S0, dat: 32'd0, sel: 4'hF, err: 1'b0, rdat: 32'h01, irq: 2'b00};
    run(v, 101);
    v.adr = S1;
    run(v, 102);
    v.adr = C0; v.rdat = 32'h0;
    run(v, 103);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
